// File: rtl/alu_seq.sv
// alu_seq: sequencer that drives an external datapath ALU for single-cycle
// operations and runs a WIDTH-step shift-and-add multiply through the same ALU.
// Responses are registered and held until the consumer accepts them.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    // datapath ALU
    output logic [2:0]       alu_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    input  logic             alu_zero,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_negative,
    output logic             rsp_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_SUM = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL_STEP,
        RESP
    } state_t;

    state_t state_reg;
    state_t state_next;

    // latched request
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // multiplier working registers
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;

    // registered response
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_overflow_reg;
    logic             rsp_negative_reg;
    logic             rsp_zero_reg;

    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] mul_addend;

    assign accept   = req_valid && (state_reg == IDLE);
    assign mul_last = (count_reg == CW'(WIDTH - 1));

    // Partial product for this step: the shifted multiplicand, gated per bit
    // by the current low multiplier bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign mul_addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. RESP always returns to IDLE before a new accept,
    // so there is never a same-cycle response/request overlap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (req_op == OP_MUL) ? MUL_STEP : EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            MUL_STEP: begin
                if (mul_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ALU drive: latched operation in EXEC, accumulate step in MUL_STEP, idle zeros otherwise.
    always_comb begin
        alu_funct = 3'd0;
        alu_a     = '0;
        alu_b     = '0;
        case (state_reg)
            EXEC: begin
                alu_funct = op_reg;
                alu_a     = a_reg;
                alu_b     = b_reg;
            end
            MUL_STEP: begin
                alu_funct = OP_SUM;
                alu_a     = acc_reg;
                alu_b     = mul_addend;
            end
            default: begin
                alu_funct = 3'd0;
                alu_a     = '0;
                alu_b     = '0;
            end
        endcase
    end

    // Request capture; only the accept edge updates the latched operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= 3'd0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (accept) begin
            op_reg <= req_op;
            a_reg  <= req_a;
            b_reg  <= req_b;
        end
    end

    // Shift-and-add multiplier state: load on a MUL accept, one step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (accept && (req_op == OP_MUL)) begin
            acc_reg    <= '0;
            mcand_reg  <= req_a;
            mplier_reg <= req_b;
            count_reg  <= '0;
        end else if (state_reg == MUL_STEP) begin
            acc_reg    <= alu_result;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
        end
    end

    // Response capture: ALU status only at the EXEC edge; the multiply derives
    // its own flags from the final sum and never reports overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_reg   <= '0;
            rsp_overflow_reg <= 1'b0;
            rsp_negative_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg   <= alu_result;
            rsp_overflow_reg <= alu_overflow;
            rsp_negative_reg <= alu_negative;
            rsp_zero_reg     <= alu_zero;
        end else if ((state_reg == MUL_STEP) && mul_last) begin
            rsp_result_reg   <= alu_result;
            rsp_overflow_reg <= 1'b0;
            rsp_negative_reg <= alu_result[WIDTH-1];
            rsp_zero_reg     <= (alu_result == '0);
        end
    end

    assign req_ready    = (state_reg == IDLE);
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_result   = rsp_result_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign rsp_negative = rsp_negative_reg;
    assign rsp_zero     = rsp_zero_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural datapath ALU and an
// expected-response queue filled at issue time and drained when responses appear.
module tb_alu_seq;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [2:0]   alu_funct;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_negative;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow;
    logic         rsp_negative;
    logic         rsp_zero;

    typedef struct packed {
        logic [W-1:0] result;
        logic         ovf;
        logic         neg;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_funct    (alu_funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_negative (rsp_negative),
        .rsp_zero     (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath ALU
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_funct)
            3'd0: alu_result = alu_a;
            3'd1: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'd2: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            3'd3: alu_result = alu_a & alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: begin
                alu_result   = alu_a + 64'd1;
                alu_overflow = (alu_a == 64'h7FFF_FFFF_FFFF_FFFF);
            end
            default: alu_result = alu_a * alu_b;
        endcase
        alu_negative = alu_result[W-1];
        alu_zero     = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] r, input logic o, input logic n, input logic z);
        exp_t e;
        e.result = r;
        e.ovf    = o;
        e.neg    = n;
        e.zero   = z;
        sb.push_back(e);
    endtask

    // Present a request and return at the point just after its accept edge.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 64'd1, 64'd0);
        step();
        req_valid = 1'b0;
        $display("issue op=%0d a=0x%h b=0x%h", op, a, b);
    endtask

    // Wait for the response; latency is the edge (relative to accept) at
    // which rsp_valid is first seen high. Compares against the queue head.
    task automatic wait_rsp(input int lat_exp, input bit is_mul);
        int   k    = 0;
        int   fcnt = 0;
        exp_t e;
        while (!rsp_valid && k < 200) begin
            if (alu_funct == 3'd1) fcnt++;
            step();
            k++;
        end
        if (k >= 200) begin
            check("rsp_timeout", 64'd1, 64'd0);
        end else begin
            check("latency", 64'(k + 1), 64'(lat_exp));
            if (is_mul) check("mul_sum_cycles", 64'(fcnt), 64'(W));
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_result", rsp_result, e.result);
                check("rsp_overflow", 64'(rsp_overflow), 64'(e.ovf));
                check("rsp_negative", 64'(rsp_negative), 64'(e.neg));
                check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
            end
            $display("rsp result=0x%h ovf=%0b neg=%0b zero=%0b lat=%0d",
                     rsp_result, rsp_overflow, rsp_negative, rsp_zero, k + 1);
        end
    endtask

    // Consume the response that is currently presented.
    task automatic consume();
        rsp_ready = 1'b1;
        step();
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int          acc1;
        int          acc2;
        int          hs1;
        int          n_acc;
        int          n_hs;
        logic [63:0] last_res;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #3;
        // reset state
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_flags", 64'({rsp_overflow, rsp_negative, rsp_zero}), 64'd0);
        check("rst_alu_funct", 64'(alu_funct), 64'd0);
        check("rst_alu_ab", alu_a | alu_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // SUM 5 + -7
        push(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
        issue(3'd1, 64'd5, -64'sd7);
        check("exec_funct", 64'(alu_funct), 64'd1);
        check("exec_a", alu_a, 64'd5);
        check("exec_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF9);
        wait_rsp(2, 1'b0);
        check("resp_alu_funct", 64'(alu_funct), 64'd0);
        consume();

        // SUM signed overflow
        push(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        issue(3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_rsp(2, 1'b0);
        consume();

        // MUL -3 * 7
        push(64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1, 1'b0);
        issue(3'd7, -64'sd3, 64'd7);
        check("mul_first_a", alu_a, 64'd0);
        check("mul_first_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_rsp(W + 1, 1'b1);
        consume();

        // Single-cycle ops with fixed expectations
        push(64'd0, 1'b0, 1'b0, 1'b1);
        issue(3'd0, 64'd0, 64'h1234);
        wait_rsp(2, 1'b0);
        consume();
        push(64'h00F0_00F0_00F0_00F0, 1'b0, 1'b0, 1'b0);
        issue(3'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0);
        wait_rsp(2, 1'b0);
        consume();
        push(64'hFF00_FF00_FF00_FF00, 1'b0, 1'b1, 1'b0);
        issue(3'd4, 64'hAAAA_AAAA_AAAA_AAAA, 64'h55AA_55AA_55AA_55AA);
        wait_rsp(2, 1'b0);
        consume();
        push(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        issue(3'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        wait_rsp(2, 1'b0);
        consume();

        // MUL boundaries: product wraps to zero; -1 * -1
        push(64'd0, 1'b0, 1'b0, 1'b1);
        issue(3'd7, 64'h1_0000_0000, 64'h1_0000_0000);
        wait_rsp(W + 1, 1'b1);
        consume();
        push(64'd1, 1'b0, 1'b0, 1'b0);
        issue(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_rsp(W + 1, 1'b1);
        consume();

        // Random multiplies
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            last_res = ra * rb;
            push(last_res, 1'b0, last_res[63], last_res == 64'd0);
            issue(3'd7, ra, rb);
            wait_rsp(W + 1, 1'b1);
            consume();
        end

        // NOT 0 with back-pressure; request pulses must be ignored
        rsp_ready = 1'b0;
        push(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        issue(3'd5, 64'd0, 64'd0);
        wait_rsp(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i == 1 || i == 3);
            req_op    = 3'd1;
            req_a     = 64'd1;
            req_b     = 64'd2;
            step();
            check("hold_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
            check("hold_negative", 64'(rsp_negative), 64'd1);
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_alu_funct", 64'(alu_funct), 64'd0);
        end
        req_valid = 1'b0;
        consume();
        check("retain_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_after_pulses", 64'({req_ready, rsp_valid}), 64'd2);
        end

        // Reset during MUL step 30
        issue(3'd7, 64'd5, 64'd9);
        for (int i = 0; i < 29; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_rsp_result", rsp_result, 64'd0);
        check("midrst_flags", 64'({rsp_overflow, rsp_negative, rsp_zero}), 64'd0);
        check("midrst_alu", 64'(alu_funct) | alu_a | alu_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale_rsp", 64'(rsp_valid), 64'd0);
        end
        push(64'd0, 1'b0, 1'b0, 1'b1);
        issue(3'd2, 64'd10, 64'd10);
        wait_rsp(2, 1'b0);
        consume();

        // Back-to-back SUMs with req_valid held high
        push(64'd3, 1'b0, 1'b0, 1'b0);
        push(64'd30, 1'b0, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_a     = 64'd1;
        req_b     = 64'd2;
        acc1 = -1; acc2 = -1; hs1 = -1; n_acc = 0; n_hs = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic fire;
            logic hs;
            exp_t e;
            fire = req_valid && req_ready;
            hs   = rsp_valid && rsp_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    check("b2b_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("b2b_result", rsp_result, e.result);
                end
            end
            step();
            if (fire) begin
                n_acc++;
                if (n_acc == 1) begin
                    acc1  = cyc;
                    req_a = 64'd10;
                    req_b = 64'd20;
                end else begin
                    acc2      = cyc;
                    req_valid = 1'b0;
                end
            end
            if (hs) begin
                n_hs++;
                if (n_hs == 1) hs1 = cyc;
            end
        end
        req_valid = 1'b0;
        $display("b2b accept1=%0d hs1=%0d accept2=%0d", acc1, hs1, acc2);
        check("b2b_accepts", 64'(n_acc), 64'd2);
        check("b2b_handshakes", 64'(n_hs), 64'd2);
        check("b2b_second_accept", 64'(acc2), 64'(hs1 + 1));
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
